// File: rtl/servo_pkg.sv
// Shared servo constants, scheduler FSM states and the angle clamp helper
// (the UART command decoder uses the clamp as well).
package servo_pkg;

  localparam int ANGLE_W       = 8;
  localparam int MAX_ANGLE     = 180;
  localparam int MIN_ANGLE     = 0;
  localparam int DEFAULT_ANGLE = 60;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Widened to int so the lower bound compares cleanly even when it is 0.
  function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [ANGLE_W-1:0] a);
    int v;
    v = int'(a);
    if (v > MAX_ANGLE) return ANGLE_W'(MAX_ANGLE);
    if (v < MIN_ANGLE) return ANGLE_W'(MIN_ANGLE);
    return a;
  endfunction

endpackage

// File: rtl/servo_ramp_step.sv
// Combinational next-angle for one channel: step toward the target,
// landing exactly on it once the remaining distance fits in one step.
module servo_ramp_step
  import servo_pkg::*;
(
  input  logic [ANGLE_W-1:0] cur,
  input  logic [ANGLE_W-1:0] tgt,
  input  logic [3:0]         step,
  output logic [ANGLE_W-1:0] nxt
);

  logic signed [ANGLE_W:0] diff;
  logic        [ANGLE_W:0] mag;

  assign diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
  assign mag  = diff[ANGLE_W] ? -diff : diff;

  always_comb begin
    nxt = tgt;
    if (mag > {{(ANGLE_W-3){1'b0}}, step}) begin
      if (!diff[ANGLE_W]) nxt = cur + {{(ANGLE_W-4){1'b0}}, step};
      else                nxt = cur - {{(ANGLE_W-4){1'b0}}, step};
    end
  end

endmodule

// File: rtl/servo_ramp_scheduler.sv
// Multi-channel servo target/current angle store with a shared ramp engine
// that services every channel once per ramp tick.
module servo_ramp_scheduler
  import servo_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 2,
  parameter int TICK_DIV = 50000
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      iCmdValid,
  output logic                      oCmdReady,
  input  logic [CH_W-1:0]           iCmdCh,
  input  logic [ANGLE_W-1:0]        iCmdAngle,
  input  logic [3:0]                iStep,
  output logic [NUM_CH*ANGLE_W-1:0] oAngle,
  output logic [NUM_CH-1:0]         oArrived,
  output logic                      oBusy,
  output logic                      oCmdErr
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0]                     cnt_q;
  logic                                 tick;
  state_e                               state_q, state_d;
  logic [CH_W-1:0]                      idx_q, idx_d;
  logic                                 ready;
  logic [NUM_CH-1:0][ANGLE_W-1:0]       cur_q, tgt_q;
  logic [NUM_CH-1:0]                    arrived_q;
  logic                                 err_q;
  logic                                 accept, ch_ok, clamped;
  logic [ANGLE_W-1:0]                   clamp_val, cur_sel, tgt_sel, nxt;

  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (tick) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (idx_q == CH_W'(NUM_CH - 1)) state_d = IDLE;
        else                            idx_d   = idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept    = iCmdValid & ready;
  assign ch_ok     = int'(iCmdCh) < NUM_CH;
  assign clamp_val = clamp_angle(iCmdAngle);
  assign clamped   = (clamp_val != iCmdAngle);

  always_comb begin
    cur_sel = cur_q[0];
    tgt_sel = tgt_q[0];
    for (int k = 1; k < NUM_CH; k++) begin
      if (idx_q == CH_W'(k)) begin
        cur_sel = cur_q[k];
        tgt_sel = tgt_q[k];
      end
    end
  end

  servo_ramp_step u_step (
    .cur  (cur_sel),
    .tgt  (tgt_sel),
    .step (iStep),
    .nxt  (nxt)
  );

  // Targets are written only in IDLE and currents only in SCAN, so a
  // channel never sees both updates on the same edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q     <= '0;
      state_q   <= IDLE;
      idx_q     <= '0;
      cur_q     <= {NUM_CH{ANGLE_W'(DEFAULT_ANGLE)}};
      tgt_q     <= {NUM_CH{ANGLE_W'(DEFAULT_ANGLE)}};
      arrived_q <= '1;
      err_q     <= 1'b0;
    end else begin
      cnt_q   <= tick ? '0 : cnt_q + CNT_W'(1);
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= accept & (~ch_ok | clamped);
      for (int k = 0; k < NUM_CH; k++) begin
        if (accept && ch_ok && iCmdCh == CH_W'(k)) tgt_q[k] <= clamp_val;
        if (state_q == SCAN && idx_q == CH_W'(k))  cur_q[k] <= nxt;
        arrived_q[k] <= (cur_q[k] == tgt_q[k]);
      end
    end
  end

  assign oCmdReady = ready;
  assign oAngle    = cur_q;
  assign oArrived  = arrived_q;
  assign oBusy     = ~&arrived_q;
  assign oCmdErr   = err_q;

endmodule

// File: tb/tb_servo_ramp_scheduler.sv
// Randomized scoreboard bench for servo_ramp_scheduler with a pass-level
// reference model of targets, currents and command errors.
module tb_servo_ramp_scheduler;

  localparam int NUM_CH   = 4;
  localparam int CH_W     = 2;
  localparam int AW       = 8;
  localparam int TICK_DIV = 12;
  localparam int W        = NUM_CH * AW;

  logic            Clk = 1'b0;
  logic            Rst_n;
  logic            iCmdValid;
  logic            oCmdReady;
  logic [CH_W-1:0] iCmdCh;
  logic [AW-1:0]   iCmdAngle;
  logic [3:0]      iStep;
  logic [W-1:0]    oAngle;
  logic [NUM_CH-1:0] oArrived;
  logic            oBusy;
  logic            oCmdErr;

  servo_ramp_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .TICK_DIV(TICK_DIV)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .iCmdValid(iCmdValid), .oCmdReady(oCmdReady),
    .iCmdCh(iCmdCh), .iCmdAngle(iCmdAngle), .iStep(iStep), .oAngle(oAngle),
    .oArrived(oArrived), .oBusy(oBusy), .oCmdErr(oCmdErr)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;
  int cur_m[NUM_CH];
  int tgt_m[NUM_CH];
  int step_m = 0;
  bit in_rst = 1'b1;
  logic [W-1:0]      exp_ang_q[$];
  logic [NUM_CH-1:0] exp_arr_q[$];
  bit                err_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  function automatic logic [W-1:0] model_angles();
    logic [W-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[k*AW +: AW] = AW'(cur_m[k]);
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] model_arrived();
    logic [NUM_CH-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[k] = (cur_m[k] == tgt_m[k]);
    return v;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      cur_m[k] = 60;
      tgt_m[k] = 60;
    end
  endfunction

  function automatic void model_accept(input int ch, input int ang);
    err_q.push_back(ang > 180);
    tgt_m[ch] = (ang > 180) ? 180 : ang;
  endfunction

  // Reference: each pass moves every channel by up to one step toward its target.
  initial begin
    bit prev = 1'b1;
    forever begin
      @(negedge Clk);
      if (in_rst) prev = 1'b1;
      else begin
        if (prev && !oCmdReady) begin
          for (int k = 0; k < NUM_CH; k++) begin
            int d;
            d = tgt_m[k] - cur_m[k];
            if (d <= step_m && d >= -step_m) cur_m[k] = tgt_m[k];
            else if (d > 0)                  cur_m[k] = cur_m[k] + step_m;
            else                             cur_m[k] = cur_m[k] - step_m;
          end
          exp_ang_q.push_back(model_angles());
          exp_arr_q.push_back(model_arrived());
        end
        prev = oCmdReady;
      end
    end
  end

  // Monitor: a pass ends when ready returns high; flags settle one cycle later.
  initial begin
    bit prev_r = 1'b1;
    int low = 0;
    bit pend = 1'b0;
    logic [NUM_CH-1:0] parr = '1;
    forever begin
      @(posedge Clk);
      #1;
      if (in_rst) begin
        prev_r = 1'b1;
        low    = 0;
        pend   = 1'b0;
      end else begin
        if (pend) begin
          chk("arrived", oArrived, parr);
          chk("busy", oBusy, ~&parr);
          pend = 1'b0;
        end
        if (err_q.size() != 0) chk("cmd_err", oCmdErr, err_q.pop_front());
        else                   chk("no_spurious_err", oCmdErr, 0);
        if (!oCmdReady) low++;
        if (oCmdReady && !prev_r) begin
          chk("scan_len", low, NUM_CH);
          low = 0;
          if (exp_ang_q.size() == 0) timeout("angles_no_expectation");
          else begin
            chk("angles", oAngle, exp_ang_q.pop_front());
            parr = exp_arr_q.pop_front();
            pend = 1'b1;
          end
        end
        prev_r = oCmdReady;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      iCmdValid = 1'b0;
    end
  endtask

  task automatic cmd(input int ch, input int ang, output int waited);
    waited = 0;
    forever begin
      @(negedge Clk);
      iCmdValid = 1'b1;
      iCmdCh    = CH_W'(ch);
      iCmdAngle = AW'(ang);
      if (oCmdReady) begin
        model_accept(ch, ang);
        break;
      end
      waited++;
      if (waited > 4 * TICK_DIV) begin
        timeout("cmd_accept");
        break;
      end
    end
  endtask

  task automatic set_step(input int s);
    int n = 0;
    forever begin
      @(negedge Clk);
      iCmdValid = 1'b0;
      if (oCmdReady) begin
        iStep  = 4'(s);
        step_m = s;
        break;
      end
      if (++n > 4 * TICK_DIV) begin
        timeout("set_step");
        break;
      end
    end
  endtask

  task automatic wait_level(input bit lvl, input string nm);
    int n = 0;
    forever begin
      @(negedge Clk);
      iCmdValid = 1'b0;
      if (oCmdReady == lvl) break;
      if (++n > 4 * TICK_DIV) begin
        timeout(nm);
        break;
      end
    end
  endtask

  task automatic wait_pass(input int n);
    repeat (n) begin
      wait_level(1'b0, "pass_start");
      wait_level(1'b1, "pass_end");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int cnt;
    Rst_n = 1'b0;
    iCmdValid = 1'b0;
    iCmdCh = '0;
    iCmdAngle = '0;
    iStep = '0;
    model_reset();
    repeat (3) @(negedge Clk);
    chk("rst_angles", oAngle, {NUM_CH{8'd60}});
    chk("rst_arrived", oArrived, 4'b1111);
    chk("rst_busy", oBusy, 0);
    chk("rst_ready", oCmdReady, 1);
    chk("rst_err", oCmdErr, 0);
    Rst_n = 1'b1;
    @(negedge Clk);
    in_rst = 1'b0;

    set_step(4);
    wait_pass(3);

    cmd(1, 70, w);
    wait_pass(3);

    set_step(15);
    cmd(2, 200, w);
    cmd(0, 10, w);
    wait_pass(5);

    // Command held from the first SCAN cycle waits out the whole pass.
    wait_level(1'b0, "stall_sync");
    iCmdValid = 1'b1;
    iCmdCh    = CH_W'(3);
    iCmdAngle = AW'(90);
    cnt = 1;
    forever begin
      @(negedge Clk);
      if (oCmdReady) break;
      if (++cnt > 4 * TICK_DIV) break;
    end
    chk("stall_cycles", cnt, NUM_CH);
    model_accept(3, 90);
    wait_pass(2);

    // Land a command on the tick cycle: last IDLE cycle before SCAN.
    wait_level(1'b0, "coll_sync0");
    wait_level(1'b1, "coll_sync1");
    idle(TICK_DIV - NUM_CH - 2);
    cmd(2, 150, w);
    chk("tick_collision_no_stall", w, 0);
    cmd(0, 100, w);
    cmd(0, 40, w);
    wait_pass(2);

    repeat (150) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6)      cmd($urandom_range(0, NUM_CH - 1), $urandom_range(0, 255), w);
      else if (r < 8) idle($urandom_range(1, 6));
      else            set_step($urandom_range(0, 15));
    end
    wait_pass(2);

    set_step(4);
    cmd(0, 120, w);
    wait_level(1'b0, "rst_scan_sync");
    @(negedge Clk);
    in_rst = 1'b1;
    Rst_n  = 1'b0;
    #1;
    exp_ang_q.delete();
    exp_arr_q.delete();
    err_q.delete();
    model_reset();
    chk("midscan_angles", oAngle, {NUM_CH{8'd60}});
    chk("midscan_ready", oCmdReady, 1);
    chk("midscan_arrived", oArrived, 4'b1111);
    chk("midscan_busy", oBusy, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    in_rst = 1'b0;
    wait_pass(2);
    idle(3);
    chk("scoreboard_drained", exp_ang_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
